rf_dump_ctrl: RTL and testbench

//   Hardware counterpart of the sccomp bench dump. Watches the SCPU PC for a breakpoint or a cycle

---
 rtl/sccpu_dbg_pkg.sv | 34 +++
 rtl/rf_dump_ctrl_if.sv | 19 +
 rtl/rfdump_obuf.sv | 40 ++++
 rtl/rf_dump_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rf_dump_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sccpu_dbg_pkg.sv
// -----------------------------------------------------------------------------
// sccpu_dbg_pkg
//   Shared definitions for the SCPU debug/dump logic: dump controller state
//   encoding, breakpoint/timeout cause codes, debug register-select width and
//   the stream word width.
//   No ports (package).
// -----------------------------------------------------------------------------
package sccpu_dbg_pkg;

    localparam int REG_SEL_W = 5;   // sccomp debug reg_sel width
    localparam int DATA_W    = 32;  // stream / register word width
    localparam int IDX_W     = 6;   // scan index, holds 0..32 inclusive

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_HDR  = 3'd2,
        ST_SCAN = 3'd3,
        ST_DONE = 3'd4
    } dump_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_BP   = 2'b01,
        CAUSE_TMO  = 2'b10,
        CAUSE_BOTH = 2'b11
    } dump_cause_t;

    // Breakpoint owns bit 0 and timeout bit 1, so a coincident hit reads 11.
    function automatic dump_cause_t cause_of(input logic bp_hit, input logic tmo_hit);
        return dump_cause_t'({tmo_hit, bp_hit});
    endfunction

endpackage

// File: rtl/rf_dump_ctrl_if.sv
// -----------------------------------------------------------------------------
// rf_dump_ctrl_if
//   Valid/ready word stream carrying the register dump to a sink (UART TX,
//   trace FIFO, ...).
//   Signals: dout_valid (source->sink), dout_data[31:0] (source->sink),
//            dout_ready (sink->source).
//   Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface rf_dump_ctrl_if;
    import sccpu_dbg_pkg::*;

    logic              dout_valid;
    logic [DATA_W-1:0] dout_data;
    logic              dout_ready;

    modport master (output dout_valid, output dout_data, input dout_ready);
    modport slave  (input dout_valid, input dout_data, output dout_ready);

endinterface

// File: rtl/rfdump_obuf.sv
// -----------------------------------------------------------------------------
// rfdump_obuf
//   One-entry valid/ready output register, usable by any trace source.
//   A pending word is captured whenever the register is empty or its current
//   word is being taken this cycle; a stalled word holds data and valid.
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset
//     word_valid  a word is pending at the source
//     word_data   the pending word
//     word_taken  the pending word is captured on this clock edge
//     dout        stream source (master modport)
// -----------------------------------------------------------------------------
module rfdump_obuf
    import sccpu_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_data,
    output logic              word_taken,
    rf_dump_ctrl_if.master    dout
);

    assign word_taken = word_valid && (!dout.dout_valid || dout.dout_ready);

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout.dout_valid <= 1'b0;
            dout.dout_data  <= '0;
        end else if (word_taken) begin
            dout.dout_valid <= 1'b1;
            dout.dout_data  <= word_data;
        end else if (dout.dout_ready) begin
            dout.dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_dump_ctrl.sv
// -----------------------------------------------------------------------------
// rf_dump_ctrl
//   Watches the SCPU PC for a breakpoint or a RUN-cycle timeout, freezes the
//   CPU, scans rf[0..NREG-1] through the sccomp reg_sel/reg_data debug port
//   and streams the words out on a valid/ready interface.
//   Optional feature: define RFDUMP_HDR_EN to prefix the stream with the PC
//   and instruction captured at the trigger (NREG+2 words instead of NREG).
//   Ports:
//     clk, rstn    clock, asynchronous active-low reset
//     start        arm / re-arm pulse, honoured in IDLE and DONE only
//     bp_en        breakpoint compare enable
//     bp_addr      breakpoint PC
//     pc, instr    current SCPU PC and instruction
//     cpu_halt     clock-enable kill for SCPU PC/RF/DM writes
//     reg_sel      debug register select into sccomp
//     reg_data     sccomp debug read data (combinational from reg_sel)
//     dump_done    high in DONE
//     dump_cause   01 breakpoint, 10 timeout, 11 both, 00 none
//     dout         dump word stream (master modport)
// -----------------------------------------------------------------------------
module rf_dump_ctrl
    import sccpu_dbg_pkg::*;
#(
    parameter int MAX_CYCLES = 1000,  // 0 disables the timeout
    parameter int CNT_W      = 16,
    parameter int NREG       = 32     // at most 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 bp_en,
    input  logic [31:0]          bp_addr,
    input  logic [31:0]          pc,
    input  logic [31:0]          instr,
    output logic                 cpu_halt,
    output logic [REG_SEL_W-1:0] reg_sel,
    input  logic [DATA_W-1:0]    reg_data,
    output logic                 dump_done,
    output logic [1:0]           dump_cause,
    rf_dump_ctrl_if.master       dout
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NREG);
`ifdef RFDUMP_HDR_EN
    localparam dump_state_t DUMP_ENTRY = ST_HDR;
`else
    localparam dump_state_t DUMP_ENTRY = ST_SCAN;
`endif

    dump_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    dump_cause_t       cause;
    logic              bp_hit;
    logic              tmo_hit;
    logic              trig;
    logic              word_valid;
    logic              word_taken;
    logic [DATA_W-1:0] word_data;

`ifdef RFDUMP_HDR_EN
    logic [31:0] pc_lat;
    logic [31:0] instr_lat;
    logic        hdr_idx;      // 0 = PC word next, 1 = instruction word next
`else
    logic        unused_instr;
    assign unused_instr = ^instr;
`endif

    assign bp_hit  = bp_en && (pc == bp_addr);
    assign tmo_hit = (MAX_CYCLES != 0) && (cnt == CNT_TRIG);
    assign trig    = (state == ST_RUN) && (bp_hit || tmo_hit);

    // The trigger halts combinationally so the matched instruction never
    // commits; afterwards the halt is held by every dump state.
    assign cpu_halt   = trig || ((state != ST_IDLE) && (state != ST_RUN));
    assign dump_done  = (state == ST_DONE);
    assign dump_cause = cause;
    assign reg_sel    = (state == ST_SCAN && idx != IDX_END) ? idx[REG_SEL_W-1:0] : '0;

    // Word pending at the source side of the output register.
    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        word_valid = 1'b0;
        word_data  = '0;
        case (state)
`ifdef RFDUMP_HDR_EN
            ST_HDR: begin
                word_valid = 1'b1;
                word_data  = hdr_idx ? instr_lat : pc_lat;
            end
`endif
            ST_SCAN: begin
                word_valid = (idx != IDX_END);
                // r0 is hard-wired zero in the CPU; report it as such.
                word_data  = (idx == '0) ? '0 : reg_data;
            end
            default: ;
        endcase
    end

    rfdump_obuf u_obuf (
        .clk        (clk),
        .rstn       (rstn),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_taken (word_taken),
        .dout       (dout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            cause <= CAUSE_NONE;
`ifdef RFDUMP_HDR_EN
            pc_lat    <= '0;
            instr_lat <= '0;
            hdr_idx   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        idx   <= '0;
                        cause <= CAUSE_NONE;
                    end
                end
                ST_RUN: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (trig) begin
                        state <= DUMP_ENTRY;
                        cause <= cause_of(bp_hit, tmo_hit);
`ifdef RFDUMP_HDR_EN
                        pc_lat    <= pc;
                        instr_lat <= instr;
                        hdr_idx   <= 1'b0;
`endif
                    end
                end
`ifdef RFDUMP_HDR_EN
                ST_HDR: begin
                    if (word_taken) begin
                        hdr_idx <= ~hdr_idx;
                        if (hdr_idx) state <= ST_SCAN;
                    end
                end
`endif
                ST_SCAN: begin
                    if (word_taken) idx <= idx + 1'b1;
                    // All registers loaded and the last word leaves this edge.
                    if (!word_valid && (!dout.dout_valid || dout.dout_ready))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_dump_ctrl
//   Self-checking bench for rf_dump_ctrl. A behavioural model (mode + cycle
//   counter + expected-word queue) is checked against the DUT on every falling
//   edge; scenarios cover breakpoint, timeout, coincident trigger, random
//   sink back-pressure, ignored start, restart from DONE and reset mid-scan.
//   Build with +define+RFDUMP_HDR_EN to exercise the PC/instr header words.
// -----------------------------------------------------------------------------
module tb_rf_dump_ctrl;

    localparam int MAXC = 1000;
    localparam int NREG = 32;
`ifdef RFDUMP_HDR_EN
    localparam int NWORDS = NREG + 2;
`else
    localparam int NWORDS = NREG;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = '0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        cpu_halt;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic        dump_done;
    logic [1:0]  dump_cause;
    logic [31:0] rf [NREG];
    logic        rnd_ready = 1'b0;
    logic        halt_q = 1'b0;

    rf_dump_ctrl_if dout_if ();

    rf_dump_ctrl #(.MAX_CYCLES(MAXC), .CNT_W(16), .NREG(NREG)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .instr      (instr),
        .cpu_halt   (cpu_halt),
        .reg_sel    (reg_sel),
        .reg_data   (reg_data),
        .dump_done  (dump_done),
        .dump_cause (dump_cause),
        .dout       (dout_if)
    );

    always #5 clk = ~clk;

    // sccomp debug port: combinational register read.
    assign reg_data = rf[reg_sel];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RUN, M_DUMP, M_DONE} mmode_t;
    mmode_t      mode = M_IDLE;
    mmode_t      cur;
    int          cyc = 0;
    int          run_cycle = 0;
    int          trig_rc = -1;
    int          trig_cyc = 0;
    int          last_hs_cyc = 0;
    int          hs_count = 0;
    logic [1:0]  cause_exp = '0;
    logic [31:0] expq [$];
    logic [31:0] exp_word;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        bp_m, tmo_m;

    always @(negedge clk) begin
        cyc++;
        cur = mode;
        if (!rstn) begin
            check("rst_halt", cpu_halt, 1'b0);
            check("rst_valid", dout_if.dout_valid, 1'b0);
            check("rst_done", dump_done, 1'b0);
            check("rst_cause", dump_cause, 2'b00);
            mode = M_IDLE;
            expq.delete();
            prev_stall = 1'b0;
        end else begin
            case (cur)
                M_IDLE: begin
                    check("idle_halt", cpu_halt, 1'b0);
                    check("idle_valid", dout_if.dout_valid, 1'b0);
                    check("idle_done", dump_done, 1'b0);
                    check("idle_cause", dump_cause, 2'b00);
                end
                M_RUN: begin
                    bp_m  = bp_en && (pc == bp_addr);
                    tmo_m = (run_cycle == MAXC - 1);
                    check("run_halt", cpu_halt, bp_m || tmo_m);
                    check("run_valid", dout_if.dout_valid, 1'b0);
                    check("run_done", dump_done, 1'b0);
                    check("run_cause", dump_cause, 2'b00);
                    if (bp_m || tmo_m) begin
                        cause_exp = {tmo_m, bp_m};
                        trig_rc   = run_cycle;
                        trig_cyc  = cyc;
                        expq.delete();
`ifdef RFDUMP_HDR_EN
                        expq.push_back(pc);
                        expq.push_back(instr);
`endif
                        for (int k = 0; k < NREG; k++) expq.push_back(k == 0 ? 32'h0 : rf[k]);
                        prev_stall = 1'b0;
                        mode = M_DUMP;
                    end else begin
                        run_cycle++;
                    end
                end
                M_DUMP: begin
                    check("dump_halt", cpu_halt, 1'b1);
                    check("dump_done_low", dump_done, 1'b0);
                    check("dump_cause", dump_cause, cause_exp);
                    if (prev_stall) begin
                        check("stall_valid", dout_if.dout_valid, 1'b1);
                        check("stall_data", dout_if.dout_data, prev_data);
                    end
                    if (dout_if.dout_valid && dout_if.dout_ready) begin
                        if (expq.size() == 0) begin
                            n_checks++;
                            $display("FAIL extra_word: got %h expected no word at %0t",
                                     dout_if.dout_data, $time);
                        end else begin
                            exp_word = expq.pop_front();
                            check($sformatf("word%0d", hs_count), dout_if.dout_data, exp_word);
                            hs_count++;
                            if (expq.size() == 0) begin
                                last_hs_cyc = cyc;
                                mode = M_DONE;
                            end
                        end
                    end
                    prev_stall = dout_if.dout_valid && !dout_if.dout_ready;
                    prev_data  = dout_if.dout_data;
                end
                M_DONE: begin
                    check("done_halt", cpu_halt, 1'b1);
                    check("done_flag", dump_done, 1'b1);
                    check("done_valid", dout_if.dout_valid, 1'b0);
                    check("done_cause", dump_cause, cause_exp);
                end
                default: ;
            endcase
            if (start && (cur == M_IDLE || cur == M_DONE)) begin
                mode      = M_RUN;
                run_cycle = 0;
                hs_count  = 0;
                cause_exp = 2'b00;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One clock: the CPU advances its PC unless it was halted, the sink
    // changes ready. All drives land 1 time unit after the rising edge.
    task automatic step();
        @(negedge clk);
        halt_q = cpu_halt;
        @(posedge clk);
        #1;
        if (!halt_q) begin
            pc    = pc + 32'd4;
            instr = $urandom;
        end
        dout_if.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic arm();
        start = 1'b1;
        step();
        start = 1'b0;
        pc    = 32'h0;
        instr = $urandom;
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (mode != M_DONE && n < budget) begin
            step();
            n++;
        end
        if (mode != M_DONE) begin
            n_checks++;
            $display("FAIL dump_timeout: got no DONE expected DONE within %0d cycles", budget);
        end
    endtask

    task automatic wait_words(input int nwords, input int budget);
        int n = 0;
        while (!(mode == M_DUMP && hs_count >= nwords) && n < budget) begin
            step();
            n++;
        end
        if (!(mode == M_DUMP && hs_count >= nwords)) begin
            n_checks++;
            $display("FAIL word_wait: got %0d words expected %0d within %0d cycles",
                     hs_count, nwords, budget);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"}, cpu_halt, 1'b0);
        check({tag, "_reg_sel"}, reg_sel, 5'd0);
        check({tag, "_valid"}, dout_if.dout_valid, 1'b0);
        check({tag, "_data"}, dout_if.dout_data, 32'h0);
        check({tag, "_done"}, dump_done, 1'b0);
        check({tag, "_cause"}, dump_cause, 2'b00);
    endtask

    initial begin
        dout_if.dout_ready = 1'b1;
        for (int k = 0; k < NREG; k++) rf[k] = $urandom;
        rf[0] = 32'hDEAD_BEEF;  // must never appear: r0 reads as zero

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rstn = 1'b1;
        step();

        // Breakpoint at 0x48, full-rate sink.
        bp_en = 1'b1; bp_addr = 32'h48; rnd_ready = 1'b0;
        arm();
        run_until_done(300);
        check("bp_trig_cycle", trig_rc, 18);
        check("bp_cause", dump_cause, 2'b01);
        check("bp_latency", last_hs_cyc - trig_cyc, NWORDS + 1);
        check("bp_words", hs_count, NWORDS);

        // Restart from DONE: halt drops at once, cause clears, same dump again.
        arm();
        #1;
        check("restart_halt", cpu_halt, 1'b0);
        check("restart_cause", dump_cause, 2'b00);
        check("restart_done", dump_done, 1'b0);
        run_until_done(300);
        check("bp2_trig_cycle", trig_rc, 18);
        check("bp2_cause", dump_cause, 2'b01);
        check("bp2_latency", last_hs_cyc - trig_cyc, NWORDS + 1);

        // Timeout, random back-pressure, stray start mid-dump.
        bp_en = 1'b0; rnd_ready = 1'b1;
        arm();
        wait_words(3, 2000);
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(2000);
        check("tmo_trig_cycle", trig_rc, 999);
        check("tmo_cause", dump_cause, 2'b10);

        // Breakpoint and timeout on the same cycle.
        bp_en = 1'b1; bp_addr = 32'd999 * 32'd4;
        arm();
        run_until_done(3000);
        check("both_trig_cycle", trig_rc, 999);
        check("both_cause", dump_cause, 2'b11);

        // Reset after word 10 is accepted, then a clean re-run.
        bp_addr = 32'h48;
        arm();
        wait_words(11, 500);
        rstn = 1'b0;
        #1;
        check_reset_outputs("midscan_rst");
        step();
        step();
        rstn = 1'b1;
        step();
        rnd_ready = 1'b0;
        arm();
        run_until_done(300);
        check("rearm_trig_cycle", trig_rc, 18);
        check("rearm_cause", dump_cause, 2'b01);
        check("rearm_words", hs_count, NWORDS);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
